// File: rtl/dmem_scan.sv
// Data-memory scan engine: walks a contiguous (wrapping) address range through
// the memory's read-only port and streams words out with address, last flag and checksum.
module dmem_scan #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  output logic [AW-1:0] radd,
  input  logic [DW-1:0] rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] radd_q, radd_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          handshake;

  assign handshake = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    radd_d      = radd_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    sum_d       = sum_q;

    // The checksum counts every accepted word, including one accepted alongside abort.
    if (handshake) begin
      sum_d = sum_q + out_data_q;
    end

    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sum_d = '0;
            if (count == '0) begin
              done_d = 1'b1;
            end else begin
              state_d     = RUN;
              radd_d      = base;
              remaining_d = count;
            end
          end
        end
        RUN: begin
          // Fetch whenever the output slot is empty or being emptied this cycle.
          if (!out_valid_q || out_ready) begin
            out_data_d  = rdata;
            out_addr_d  = radd_q;
            out_valid_d = 1'b1;
            out_last_d  = (remaining_q == (AW+1)'(1));
            radd_d      = radd_q + AW'(1);
            remaining_d = remaining_q - (AW+1)'(1);
            if (remaining_q == (AW+1)'(1)) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
            done_d      = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      radd_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      radd_q      <= radd_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      sum_q       <= sum_d;
    end
  end

  assign radd      = radd_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = done_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_dmem_scan.sv
// Self-checking bench for dmem_scan: a behavioural memory on the read port and
// a reference model computing expected words and checksums from address arithmetic.
module tb_dmem_scan;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        abort;
  logic [7:0]  base;
  logic [8:0]  count;
  logic [7:0]  radd;
  logic [31:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [31:0] sum;

  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  // Observations from the most recent run_scan call.
  logic [31:0] got_data [$];
  logic [7:0]  got_addr [$];
  logic        got_last [$];
  int          got_it   [$];
  int          first_valid_it, last_hs_it, done_it, done_pulses, stall_viol;
  logic [7:0]  radd0;
  logic        busy0, busy_at_done;

  always #5 clk = ~clk;

  assign rdata = mem[radd];

  dmem_scan #(.AW(8), .DW(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base(base), .count(count), .radd(radd), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done), .sum(sum)
  );

  function automatic logic [31:0] exp_word(input logic [7:0] b, input int i);
    logic [7:0] a;
    a = b + 8'(i);
    return mem[a];
  endfunction

  function automatic logic [31:0] exp_sum(input logic [7:0] b, input int n);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < n; i++) s = s + exp_word(b, i);
    return s;
  endfunction

  // Drives one scan and records what the consumer saw; mode selects out_ready:
  // 0 always high, 1 pattern 1,0,0, 2 random, 3 low for 5 cycles then high.
  task automatic run_scan(input logic [7:0] b, input logic [8:0] n, input int mode, input bit poke);
    logic        prev_stall, r;
    logic [31:0] prev_data;
    logic [7:0]  prev_addr, prev_radd;
    logic        prev_last;
    got_data.delete(); got_addr.delete(); got_last.delete(); got_it.delete();
    first_valid_it = -1; last_hs_it = -1; done_it = -1; done_pulses = 0; stall_viol = 0;
    busy_at_done = 1'b1; prev_stall = 1'b0;
    prev_data = '0; prev_addr = '0; prev_radd = '0; prev_last = 1'b0;
    @(negedge clk);
    base = b; count = n; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      if (it == 0) begin radd0 = radd; busy0 = busy; end
      if (done === 1'b1) begin
        done_pulses++;
        if (done_it < 0) begin done_it = it; busy_at_done = busy; end
      end
      if (out_valid === 1'b1 && first_valid_it < 0) first_valid_it = it;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_addr !== prev_addr ||
                         out_last !== prev_last || radd !== prev_radd)) stall_viol++;
      case (mode)
        0:       r = 1'b1;
        1:       r = ((it % 3) == 0);
        2:       r = 1'($urandom % 2);
        default: r = (it >= 5);
      endcase
      if (poke && it == 3) begin
        start = 1'b1; base = ~b; count = 9'd3;
      end else begin
        start = 1'b0;
      end
      out_ready = r;
      if (out_valid === 1'b1 && r) begin
        got_data.push_back(out_data); got_addr.push_back(out_addr);
        got_last.push_back(out_last); got_it.push_back(it);
        last_hs_it = it;
      end
      prev_stall = (out_valid === 1'b1) && !r;
      prev_data = out_data; prev_addr = out_addr; prev_last = out_last; prev_radd = radd;
      if (done_it >= 0 && it >= done_it + 2) break;
      @(negedge clk);
    end
    out_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; base = '0; count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({radd, out_valid, out_data, out_addr, out_last, busy, done, sum} !== '0) begin
      bad++;
      $display("FAIL reset_in: radd=%h v=%b d=%h a=%h l=%b busy=%b done=%b sum=%h, want all 0",
               radd, out_valid, out_data, out_addr, out_last, busy, done, sum);
    end
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if ({radd, out_valid, out_data, out_addr, out_last, busy, done, sum} !== '0) begin
      bad++;
      $display("FAIL reset_after: radd=%h v=%b busy=%b done=%b sum=%h, want all 0",
               radd, out_valid, busy, done, sum);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 256; i++) mem[i] = i + 1;
    run_scan(8'h10, 9'd4, 0, 1'b0);
    total++;
    if (radd0 !== 8'h10 || busy0 !== 1'b1) begin
      bad++; $display("FAIL basic_start: radd=%h busy=%b, want 10 1", radd0, busy0);
    end
    total++;
    if (first_valid_it !== 1) begin
      bad++; $display("FAIL basic_latency: first valid cycle %0d, want 1", first_valid_it);
    end
    total++;
    if (got_data.size() !== 4) begin
      bad++; $display("FAIL basic_count: got %0d words, want 4", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 32'h11 + 32'(i) || got_addr[i] !== 8'h10 + 8'(i) ||
          got_last[i] !== (i == 3) || got_it[i] !== 1 + i) begin
        bad++;
        $display("FAIL basic_word%0d: d=%h a=%h l=%b cyc=%0d, want d=%h a=%h l=%b cyc=%0d", i,
                 got_data[i], got_addr[i], got_last[i], got_it[i], 32'h11 + 32'(i),
                 8'h10 + 8'(i), (i == 3), 1 + i);
      end
    end
    total++;
    if (done_it !== last_hs_it + 1 || done_pulses !== 1 || busy_at_done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: done cyc=%0d pulses=%0d busy=%b, want cyc=%0d pulses=1 busy=0",
               done_it, done_pulses, busy_at_done, last_hs_it + 1);
    end
    total++;
    if (sum !== 32'h4A) begin
      bad++; $display("FAIL basic_sum: sum=%h, want 4a", sum);
    end
  endtask

  task automatic test_wrap;
    run_scan(8'hFE, 9'd3, 0, 1'b0);
    total++;
    if (got_addr.size() !== 3) begin
      bad++; $display("FAIL wrap_count: got %0d words, want 3", got_addr.size());
    end
    for (int i = 0; i < got_addr.size(); i++) begin
      total++;
      if (got_addr[i] !== 8'(254 + i) || got_data[i] !== exp_word(8'hFE, i) ||
          got_last[i] !== (i == 2)) begin
        bad++;
        $display("FAIL wrap_word%0d: a=%h d=%h l=%b, want a=%h d=%h l=%b", i, got_addr[i],
                 got_data[i], got_last[i], 8'(254 + i), exp_word(8'hFE, i), (i == 2));
      end
    end
    total++;
    if (sum !== exp_sum(8'hFE, 3)) begin
      bad++; $display("FAIL wrap_sum: sum=%h, want %h", sum, exp_sum(8'hFE, 3));
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] b;
    logic [8:0] n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      n = (k == 0) ? 9'd5 : 9'($urandom_range(2, 30));
      run_scan(b, n, (k < 2) ? 1 : 2, 1'b0);
      total++;
      if (stall_viol !== 0) begin
        bad++; $display("FAIL bp%0d_stable: %0d unstable stall cycles, want 0", k, stall_viol);
      end
      total++;
      if (got_data.size() !== int'(n)) begin
        bad++; $display("FAIL bp%0d_count: got %0d words, want %0d", k, got_data.size(), n);
      end
      for (int i = 0; i < got_data.size(); i++) begin
        total++;
        if (got_data[i] !== exp_word(b, i) || got_addr[i] !== 8'(b + i) ||
            got_last[i] !== (i == int'(n) - 1)) begin
          bad++;
          $display("FAIL bp%0d_word%0d: d=%h a=%h l=%b, want d=%h a=%h", k, i, got_data[i],
                   got_addr[i], got_last[i], exp_word(b, i), 8'(b + i));
        end
      end
      total++;
      if (sum !== exp_sum(b, int'(n)) || done_pulses !== 1) begin
        bad++;
        $display("FAIL bp%0d_sum: sum=%h pulses=%0d, want %h 1", k, sum, done_pulses,
                 exp_sum(b, int'(n)));
      end
    end
  endtask

  task automatic test_count_zero;
    run_scan(8'h40, 9'd0, 0, 1'b0);
    total++;
    if (first_valid_it !== -1 || done_pulses !== 1) begin
      bad++;
      $display("FAIL zero_count: valid cyc=%0d done pulses=%0d, want -1 1",
               first_valid_it, done_pulses);
    end
    total++;
    if (sum !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_sum: sum=%h busy=%b, want 0 0", sum, busy);
    end
  endtask

  task automatic test_abort;
    logic [7:0] b;
    int hs, stalled, dpulse;
    bit fired;
    b = 8'($urandom);
    hs = 0; stalled = 0; fired = 1'b0; dpulse = 0;
    @(negedge clk);
    base = b; count = 9'd8; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 50 && !fired; it++) begin
      if (out_valid === 1'b1 && hs == 2) begin
        out_ready = 1'b0;
        stalled++;
        if (stalled == 2) begin abort = 1'b1; fired = 1'b1; end
      end else begin
        out_ready = 1'b1;
        if (out_valid === 1'b1) hs++;
      end
      @(negedge clk);
    end
    abort = 1'b0; out_ready = 1'b0;
    total++;
    if (!fired) begin
      bad++; $display("FAIL abort_reach: 3rd word never stalled, handshakes=%0d want 2", hs);
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL abort_state: v=%b busy=%b l=%b, want 0 0 0", out_valid, busy, out_last);
    end
    total++;
    if (sum !== exp_sum(b, 2)) begin
      bad++; $display("FAIL abort_sum: sum=%h, want %h", sum, exp_sum(b, 2));
    end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dpulse++;
      @(negedge clk);
    end
    total++;
    if (dpulse !== 0) begin
      bad++; $display("FAIL abort_done: %0d done pulses, want 0", dpulse);
    end
    b = 8'($urandom);
    run_scan(b, 9'd6, 0, 1'b0);
    total++;
    if (got_data.size() !== 6 || sum !== exp_sum(b, 6) || done_pulses !== 1) begin
      bad++;
      $display("FAIL abort_rescan: words=%0d sum=%h pulses=%0d, want 6 %h 1",
               got_data.size(), sum, done_pulses, exp_sum(b, 6));
    end
  endtask

  task automatic test_reset_mid;
    int dpulse;
    dpulse = 0;
    @(negedge clk);
    base = 8'h33; count = 9'd20; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({radd, out_valid, out_data, out_addr, out_last, busy, done, sum} !== '0) begin
      bad++;
      $display("FAIL reset_mid: radd=%h v=%b d=%h a=%h busy=%b sum=%h, want all 0",
               radd, out_valid, out_data, out_addr, busy, sum);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || out_valid === 1'b1) dpulse++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++;
    if (dpulse !== 0) begin
      bad++; $display("FAIL reset_mid_quiet: %0d cycles with done/valid, want 0", dpulse);
    end
  endtask

  task automatic test_start_ignored;
    logic [7:0] b;
    b = 8'($urandom);
    run_scan(b, 9'd6, 3, 1'b1);
    total++;
    if (stall_viol !== 0) begin
      bad++; $display("FAIL restart_stable: %0d unstable stall cycles, want 0", stall_viol);
    end
    total++;
    if (got_data.size() !== 6) begin
      bad++; $display("FAIL restart_count: got %0d words, want 6", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_word(b, i) || got_addr[i] !== 8'(b + i)) begin
        bad++;
        $display("FAIL restart_word%0d: d=%h a=%h, want d=%h a=%h", i, got_data[i],
                 got_addr[i], exp_word(b, i), 8'(b + i));
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic [8:0] n;
    int errs;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      b = 8'($urandom);
      n = (k == 7) ? 9'd256 : 9'($urandom_range(1, 40));
      run_scan(b, n, (k == 7) ? 0 : 2, 1'b0);
      errs = 0;
      for (int i = 0; i < got_data.size(); i++) begin
        if (got_data[i] !== exp_word(b, i) || got_addr[i] !== 8'(b + i) ||
            got_last[i] !== (i == int'(n) - 1)) errs++;
      end
      total++;
      if (errs !== 0 || got_data.size() !== int'(n) || done_pulses !== 1) begin
        bad++;
        $display("FAIL rand%0d_stream: words=%0d bad words=%0d pulses=%0d, want %0d 0 1", k,
                 got_data.size(), errs, done_pulses, n);
      end
      total++;
      if (sum !== exp_sum(b, int'(n))) begin
        bad++; $display("FAIL rand%0d_sum: sum=%h, want %h", k, sum, exp_sum(b, int'(n)));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
